// File: rtl/sata_link_arbiter.sv
// Grants the link read/write engines onto the single PHY transmit path,
// resolves X_RDY collisions and inserts the periodic ALIGN pair.
module sata_link_arbiter #(
  parameter int unsigned ALIGN_INTERVAL = 256,
  parameter int unsigned START_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_ready,
  input  logic        is_device,
  input  logic        detect_x_rdy,
  input  logic        wr_req,
  input  logic        wr_idle,
  input  logic        wr_xrdy_phase,
  input  logic [31:0] wr_tx_dout,
  input  logic        wr_tx_isk,
  input  logic        rd_idle,
  input  logic [31:0] rd_tx_dout,
  input  logic        rd_tx_isk,
  output logic        wr_en,
  output logic        rd_en,
  output logic        align_hold,
  output logic [31:0] tx_dout,
  output logic        tx_isk,
  output logic [1:0]  arb_state
);

  localparam int unsigned AW = ($clog2(ALIGN_INTERVAL) > 8) ? $clog2(ALIGN_INTERVAL) : 8;
  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);
  localparam logic [AW-1:0] SLOT_START = AW'(ALIGN_INTERVAL - 2);
  localparam logic [AW-1:0] ACNT_LAST  = AW'(ALIGN_INTERVAL - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [31:0]   PRIM_ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0]   PRIM_SYNC  = 32'hB5B5_957C;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_READ    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] acnt;
  logic [TW-1:0] timer;
  logic          busy_seen;
  logic          eng_idle;

  assign wr_en      = (state == S_WRITE);
  assign rd_en      = (state == S_READ);
  assign arb_state  = state;
  assign align_hold = (acnt >= SLOT_START);
  assign eng_idle   = (state == S_READ) ? rd_idle : wr_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acnt      <= '0;
      timer     <= '0;
      busy_seen <= 1'b0;
      tx_dout   <= PRIM_SYNC;
      tx_isk    <= 1'b1;
    end else begin
      if (!phy_ready || align_hold) begin
        tx_dout <= PRIM_ALIGN;
        tx_isk  <= 1'b1;
      end else if (state == S_WRITE) begin
        tx_dout <= wr_tx_dout;
        tx_isk  <= wr_tx_isk;
      end else if (state == S_READ) begin
        tx_dout <= rd_tx_dout;
        tx_isk  <= rd_tx_isk;
      end else begin
        tx_dout <= PRIM_SYNC;
        tx_isk  <= 1'b1;
      end

      if (!phy_ready || acnt == ACNT_LAST) acnt <= '0;
      else                                 acnt <= acnt + AW'(1);

      // The whole FSM is frozen during an ALIGN slot, so a pending grant
      // change lands on the first cycle after the slot.
      if (!phy_ready) begin
        state     <= S_IDLE;
        timer     <= '0;
        busy_seen <= 1'b0;
      end else if (!align_hold) begin
        case (state)
          S_IDLE: begin
            timer     <= '0;
            busy_seen <= 1'b0;
            if (detect_x_rdy && wr_req) state <= is_device ? S_WRITE : S_READ;
            else if (detect_x_rdy)      state <= S_READ;
            else if (wr_req)            state <= S_WRITE;
          end
          S_WRITE, S_READ: begin
            if (state == S_WRITE && !is_device && detect_x_rdy && wr_xrdy_phase) begin
              state     <= S_READ;
              timer     <= '0;
              busy_seen <= 1'b0;
            end else if (eng_idle && (busy_seen || timer == TIMER_LAST)) begin
              state     <= S_RELEASE;
              timer     <= '0;
              busy_seen <= 1'b0;
            end else begin
              busy_seen <= busy_seen | ~eng_idle;
              if (!busy_seen && eng_idle) timer <= timer + TW'(1);
            end
          end
          default: begin
            state     <= S_IDLE;
            timer     <= '0;
            busy_seen <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
